// File: rtl/weight_loader.sv
// Weight loader: streams ROW rows into the top of a systolic array,
// zero rows first, then the real rows, then holds conv_ctrl high.
module weight_loader #(
    parameter int COL = 32,
    parameter int ROW = 32,
    parameter int DW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        weight_dim,
    input  logic              clear,
    input  logic              wt_valid,
    input  logic [COL*DW-1:0] wt_data,
    output logic              wt_ready,
    output logic [COL*DW-1:0] w_row_data,
    output logic              w_shift,
    output logic              conv_ctrl,
    output logic              busy,
    output logic [5:0]        shift_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PAD  = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    localparam logic [5:0] ROW_C = 6'(ROW);

    logic [1:0]        state_q, state_d;
    logic [5:0]        pad_len_q, pad_len_d;
    logic [COL*DW-1:0] row_q, row_d;
    logic              shift_q, shift_d;
    logic              conv_q, conv_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [5:0]        cnt_inc;
    logic [5:0]        dim_w;

    assign dim_w   = {1'b0, weight_dim};
    assign cnt_inc = (cnt_q == ROW_C) ? cnt_q : cnt_q + 6'd1;

    always_comb begin
        state_d   = state_q;
        pad_len_d = pad_len_q;
        row_d     = row_q;
        shift_d   = 1'b0;
        conv_d    = conv_q;
        cnt_d     = cnt_q;
        if (clear) begin
            state_d = S_IDLE;
            conv_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_d  = '0;
                        conv_d = 1'b0;
                        if (dim_w < ROW_C) begin
                            pad_len_d = ROW_C - dim_w;
                            state_d   = S_PAD;
                        end else begin
                            pad_len_d = '0;
                            state_d   = S_LOAD;
                        end
                    end
                end
                S_PAD: begin
                    shift_d = 1'b1;
                    row_d   = '0;
                    cnt_d   = cnt_inc;
                    // A full-length pad means no real rows follow
                    if (cnt_inc == pad_len_q) begin
                        state_d = (pad_len_q == ROW_C) ? S_RUN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (wt_valid) begin
                        shift_d = 1'b1;
                        row_d   = wt_data;
                        cnt_d   = cnt_inc;
                        if (cnt_inc == ROW_C) begin
                            state_d = S_RUN;
                        end
                    end
                end
                default: begin
                    conv_d = 1'b1;
                end
            endcase
        end
        ready_d = (state_d == S_LOAD);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pad_len_q <= '0;
            row_q     <= '0;
            shift_q   <= 1'b0;
            conv_q    <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pad_len_q <= pad_len_d;
            row_q     <= row_d;
            shift_q   <= shift_d;
            conv_q    <= conv_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wt_ready   = ready_q;
    assign w_row_data = row_q;
    assign w_shift    = shift_q;
    assign conv_ctrl  = conv_q;
    assign busy       = busy_q;
    assign shift_cnt  = cnt_q;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: counter-based reference model checked every
// cycle, plus literal timing/count expectations for the key scenarios.
module tb_weight_loader;

    localparam int COL = 4;
    localparam int ROW = 32;
    localparam int DW  = 8;
    localparam int W   = COL * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [4:0]    weight_dim = '0;
    logic          clear = 1'b0;
    logic          wt_valid = 1'b0;
    logic [W-1:0]  wt_data = '0;
    logic          wt_ready;
    logic [W-1:0]  w_row_data;
    logic          w_shift;
    logic          conv_ctrl;
    logic          busy;
    logic [5:0]    shift_cnt;

    int errors = 0;
    int checks = 0;

    weight_loader #(.COL(COL), .ROW(ROW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .weight_dim (weight_dim),
        .clear      (clear),
        .wt_valid   (wt_valid),
        .wt_data    (wt_data),
        .wt_ready   (wt_ready),
        .w_row_data (w_row_data),
        .w_shift    (w_shift),
        .conv_ctrl  (conv_ctrl),
        .busy       (busy),
        .shift_cnt  (shift_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pads still owed, real rows still owed, run flag.
    int           m_pad = 0;
    int           m_data = 0;
    int           m_cnt = 0;
    int           m_d = 0;
    bit           m_busy = 0;
    bit           m_shift = 0;
    bit           m_conv = 0;
    bit           m_ready = 0;
    logic [W-1:0] m_row = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pad = 0; m_data = 0; m_cnt = 0;
            m_busy = 0; m_shift = 0; m_conv = 0; m_ready = 0;
            m_row = '0;
        end else if (clear) begin
            m_pad = 0; m_data = 0; m_cnt = 0;
            m_busy = 0; m_shift = 0; m_conv = 0; m_ready = 0;
        end else if (!m_busy) begin
            m_shift = 0;
            if (start) begin
                m_d = (int'(weight_dim) < ROW) ? int'(weight_dim) : ROW;
                m_pad = ROW - m_d;
                m_data = m_d;
                m_cnt = 0;
                m_busy = 1;
                m_conv = 0;
                m_ready = (m_pad == 0 && m_data > 0);
            end
        end else if (m_pad > 0) begin
            m_shift = 1;
            m_row = '0;
            m_cnt++;
            m_pad--;
            m_ready = (m_pad == 0 && m_data > 0);
        end else if (m_data > 0) begin
            m_shift = wt_valid;
            if (wt_valid) begin
                m_row = wt_data;
                m_cnt++;
                m_data--;
            end
            m_ready = (m_data > 0);
        end else begin
            m_shift = 0;
            m_conv = 1;
        end
    end

    always @(negedge clk) begin
        chk("wt_ready", 64'(wt_ready), 64'(m_ready));
        chk("w_shift", 64'(w_shift), 64'(m_shift));
        chk("w_row_data", 64'(w_row_data), 64'(m_row));
        chk("conv_ctrl", 64'(conv_ctrl), 64'(m_conv));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("shift_cnt", 64'(shift_cnt), 64'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // mode 0: valid held high, 1: valid on odd edges, 2: random + stray starts
    task automatic do_load(input int d, input int mode, output int edges,
                           output int pulses, output bit saw_ready);
        start = 1'b1;
        weight_dim = 5'(d);
        wt_valid = 1'b0;
        wt_data = $urandom;
        tick();
        start = 1'b0;
        edges = 0;
        pulses = 0;
        saw_ready = 0;
        while (!conv_ctrl && edges < 200) begin
            edges++;
            if (mode == 0) wt_valid = 1'b1;
            else if (mode == 1) wt_valid = edges[0];
            else wt_valid = 1'($urandom % 2);
            wt_data = $urandom;
            if (mode == 2) begin
                start = ($urandom % 8 == 0);
                weight_dim = 5'($urandom);
            end
            tick();
            start = 1'b0;
            wt_valid = 1'b0;
            if (w_shift) pulses++;
            if (wt_ready) saw_ready = 1;
        end
        chk("load_timeout", 64'(conv_ctrl), 64'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    int  e, p;
    bit  r;

    initial begin
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(shift_cnt), 64'd0);
        rst = 1'b0;
        tick();

        do_load(31, 0, e, p, r);
        chk("full_edges", 64'(e), 64'd33);
        chk("full_pulses", 64'(p), 64'd32);
        chk("full_cnt", 64'(shift_cnt), 64'd32);
        do_clear();

        do_load(4, 1, e, p, r);
        chk("gap_edges", 64'(e), 64'd36);
        chk("gap_pulses", 64'(p), 64'd32);
        chk("gap_cnt", 64'(shift_cnt), 64'd32);
        do_clear();

        do_load(0, 0, e, p, r);
        chk("zero_edges", 64'(e), 64'd33);
        chk("zero_pulses", 64'(p), 64'd32);
        chk("zero_ready", 64'(r), 64'd0);

        start = 1'b1;
        weight_dim = 5'd7;
        tick();
        start = 1'b0;
        chk("run_shift", 64'(w_shift), 64'd0);
        chk("run_conv", 64'(conv_ctrl), 64'd1);
        chk("run_cnt", 64'(shift_cnt), 64'd32);
        repeat (2) tick();
        chk("run_busy", 64'(busy), 64'd1);
        do_clear();

        start = 1'b1;
        weight_dim = 5'd4;
        tick();
        start = 1'b0;
        wt_valid = 1'b1;
        repeat (30) begin
            wt_data = $urandom;
            tick();
        end
        chk("abort_pre_cnt", 64'(shift_cnt), 64'd30);
        wt_valid = 1'b0;
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_conv", 64'(conv_ctrl), 64'd0);
        chk("abort_cnt", 64'(shift_cnt), 64'd0);
        chk("abort_ready", 64'(wt_ready), 64'd0);
        do_load(int'($urandom_range(1, 31)), 0, e, p, r);
        chk("reload_pulses", 64'(p), 64'd32);
        do_clear();

        start = 1'b1;
        weight_dim = 5'd10;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_shift", 64'(w_shift), 64'd0);
        chk("arst_cnt", 64'(shift_cnt), 64'd0);
        chk("arst_row", 64'(w_row_data), 64'd0);
        chk("arst_ready", 64'(wt_ready), 64'd0);
        chk("arst_conv", 64'(conv_ctrl), 64'd0);
        start = 1'b1;
        tick();
        chk("arst_start_ign", 64'(busy), 64'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("arst_after", 64'(busy), 64'd0);

        for (int i = 0; i < 8; i++) begin
            do_load(int'($urandom_range(0, 31)), 2, e, p, r);
            chk("rand_pulses", 64'(p), 64'd32);
            repeat (int'($urandom_range(0, 3))) tick();
            do_clear();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
